// File: rtl/io_bus_arbiter_if.sv
// Shared bus bundle between the two requesters, the arbiter and the slave decoder.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              m0_req,  m1_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [CTRL_W-1:0] m0_ctrl, m1_ctrl;
  logic [DATA_W-1:0] m0_wd,   m1_wd;
  logic              m0_we,   m1_we;
  logic              m0_gnt,  m1_gnt;
  logic              m0_done, m1_done;
  logic [DATA_W-1:0] m_rd;
  logic              m_err;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_wd;
  logic              s_we;
  logic              s_ready;
  logic [DATA_W-1:0] s_rd;

  modport master (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_ctrl, m1_ctrl,
           m0_wd, m1_wd, m0_we, m1_we, s_ready, s_rd,
    output m0_gnt, m1_gnt, m0_done, m1_done, m_rd, m_err,
           s_valid, s_addr, s_ctrl, s_wd, s_we
  );

  modport slave (
    output m0_req, m1_req, m0_addr, m1_addr, m0_ctrl, m1_ctrl,
           m0_wd, m1_wd, m0_we, m1_we, s_ready, s_rd,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m_rd, m_err,
           s_valid, s_addr, s_ctrl, s_wd, s_we
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter: grants the slave bus, runs one valid/ready
// transaction at a time, returns read data and aborts hung slaves on timeout.
module io_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  io_bus_arbiter_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              gnt0_q, gnt1_q, done0_q, done1_q, err_q, valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] wd_q, rd_q;
  logic              we_q;
  logic              win_d;

  // m1 wins if it is alone, or on a tie when m0 was granted last
  always_comb begin
    win_d = bus.m1_req & (~bus.m0_req | ~last_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      ctrl_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m0_req | bus.m1_req) begin
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            last_q  <= win_d;
            addr_q  <= win_d ? bus.m1_addr : bus.m0_addr;
            ctrl_q  <= win_d ? bus.m1_ctrl : bus.m0_ctrl;
            wd_q    <= win_d ? bus.m1_wd   : bus.m0_wd;
            we_q    <= win_d ? bus.m1_we   : bus.m0_we;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // s_ready in the last allowed cycle still counts as a normal completion
          if (bus.s_ready) begin
            rd_q    <= we_q ? '0 : bus.s_rd;
            err_q   <= 1'b0;
            done0_q <= gnt0_q;
            done1_q <= gnt1_q;
            valid_q <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == LAST_CNT) begin
            rd_q    <= '0;
            err_q   <= 1'b1;
            done0_q <= gnt0_q;
            done1_q <= gnt1_q;
            valid_q <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt  = gnt0_q;
  assign bus.m1_gnt  = gnt1_q;
  assign bus.m0_done = done0_q;
  assign bus.m1_done = done1_q;
  assign bus.m_rd    = rd_q;
  assign bus.m_err   = err_q;
  assign bus.s_valid = valid_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_ctrl  = ctrl_q;
  assign bus.s_wd    = wd_q;
  assign bus.s_we    = we_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: stimulus queues expected completions,
// a monitor checks each done pulse against the queue head.
module tb_io_bus_arbiter;
  localparam int AW = 32, DW = 32, CW = 4, TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW)) bus();

  io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          m;
    logic [31:0] rd;
    bit          err;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wd;
    int          nv;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          ready_at = 1;
  logic [31:0] rd_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: asserts s_ready in BUSY cycle number ready_at (0 = never)
  int bcnt = 0;
  always @(negedge clk) begin
    if (bus.s_valid) begin
      bcnt = bcnt + 1;
      bus.s_ready = (ready_at != 0) && (bcnt == ready_at);
    end else begin
      bcnt = 0;
      bus.s_ready = 1'b0;
    end
    bus.s_rd = rd_val;
  end

  // Monitor: count s_valid cycles, check each completion against the queue head
  int vcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vcnt = 0;
    end else begin
      if (bus.s_valid) vcnt = vcnt + 1;
      if (bus.m0_done | bus.m1_done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got m0_done=%0b m1_done=%0b expected none", bus.m0_done, bus.m1_done);
        end else begin
          e = q.pop_front();
          chk("done_master", {31'd0, bus.m1_done}, {31'd0, e.m});
          chk("done_excl", {31'd0, bus.m0_done & bus.m1_done}, 32'd0);
          chk("gnt_in_done", {31'd0, e.m ? bus.m1_gnt : bus.m0_gnt}, 32'd1);
          chk("m_rd", bus.m_rd, e.rd);
          chk("m_err", {31'd0, bus.m_err}, {31'd0, e.err});
          chk("s_addr", bus.s_addr, e.addr);
          chk("s_we", {31'd0, bus.s_we}, {31'd0, e.we});
          if (e.we) chk("s_wd", bus.s_wd, e.wd);
          chk("valid_cycles", vcnt, e.nv);
        end
        vcnt = 0;
      end
    end
  end

  task automatic wait_sig(input bit want_done, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      hit = want_done ? (bus.m0_done | bus.m1_done) : (bus.m0_gnt | bus.m1_gnt);
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL wait_timeout: got no %s after %0d cycles expected one", want_done ? "done" : "gnt", n);
    end
  endtask

  task automatic set_req(input bit m, input bit v);
    if (m) bus.m1_req = v;
    else   bus.m0_req = v;
  endtask

  task automatic issue(input bit m, input logic [31:0] addr, input bit we, input logic [31:0] wd,
                       input int ra, input logic [31:0] rd, input bit chg);
    exp_t e;
    int   ng, nd;
    e.m    = m;
    e.err  = (ra == 0) || (ra > TO);
    e.nv   = e.err ? TO : ra;
    e.rd   = (we || e.err) ? 32'd0 : rd;
    e.addr = addr;
    e.we   = we;
    e.wd   = wd;
    q.push_back(e);
    ready_at = ra;
    rd_val   = rd;
    @(negedge clk);
    if (m) begin
      bus.m1_addr = addr; bus.m1_we = we; bus.m1_wd = wd; bus.m1_ctrl = 4'b0010;
    end else begin
      bus.m0_addr = addr; bus.m0_we = we; bus.m0_wd = wd; bus.m0_ctrl = 4'b0000;
    end
    set_req(m, 1'b1);
    wait_sig(1'b0, ng);
    chk("gnt_other", {31'd0, m ? bus.m0_gnt : bus.m1_gnt}, 32'd0);
    set_req(m, 1'b0);
    if (chg) begin
      if (m) bus.m1_addr = addr + 32'h10;
      else   bus.m0_addr = addr + 32'h10;
    end
    wait_sig(1'b1, nd);
    chk("latency", ng + nd, e.nv + 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    exp_t e;
    bus.m0_req = 0; bus.m1_req = 0;
    bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_ctrl = '0; bus.m1_ctrl = '0;
    bus.m0_wd = '0; bus.m1_wd = '0; bus.m0_we = 0; bus.m1_we = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    chk("rst_done_err", {29'd0, bus.m_err, bus.m1_done, bus.m0_done}, 32'd0);
    chk("rst_s_valid", {31'd0, bus.s_valid}, 32'd0);
    chk("rst_s_addr", bus.s_addr, 32'd0);
    chk("rst_m_rd", bus.m_rd, 32'd0);
    rst = 1'b0;

    issue(1'b0, 32'h0000_1000, 1'b0, 32'd0, 1, 32'hCAFE_F00D, 1'b0);
    issue(1'b1, 32'h8000_0010, 1'b1, 32'h1234_5678, 4, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h0000_2000, 1'b0, 32'd0, 0, 32'h55AA_55AA, 1'b0);
    issue(1'b0, 32'h0000_2004, 1'b0, 32'd0, TO, 32'h66BB_66BB, 1'b0);
    issue(1'b0, 32'h0000_0010, 1'b0, 32'd0, 1, 32'h0BAD_0BAD, 1'b1);
    issue(1'b0, 32'h0000_0040, 1'b1, 32'hA5A5_0001, 2, 32'h1111_2222, 1'b0);

    // Reset in the middle of a hung transaction: no completion may follow
    ready_at = 0;
    @(negedge clk);
    bus.m0_addr = 32'h3000; bus.m0_we = 1'b0; bus.m0_req = 1'b1;
    wait_sig(1'b0, n);
    bus.m0_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_valid", {31'd0, bus.s_valid}, 32'd0);
    chk("midrst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);

    // Both masters held from reset: strict alternation starting at m0
    ready_at = 1;
    rd_val = 32'h0000_0077;
    bus.m0_addr = 32'h4000; bus.m1_addr = 32'h4100;
    bus.m0_we = 1'b0; bus.m1_we = 1'b0;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.m = k[0]; e.rd = 32'h77; e.err = 1'b0; e.we = 1'b0; e.wd = '0; e.nv = 1;
      e.addr = k[0] ? 32'h4100 : 32'h4000;
      q.push_back(e);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_sig(1'b1, n);
      if (k > 0) chk("rr_spacing", n, 3);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
